// File: rtl/config_port_arb_pkg.sv
// Shared types and constants for the configurator port arbiter.
package config_port_arb_pkg;

   localparam int CAW_DEF = 15;
   localparam int CDW_DEF = 21;

   localparam int REQ_NOC = 0;
   localparam int REQ_DBG = 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_RSP     = 2'd2
   } arb_state_e;

   // One-hot pick between two requesters; on contention the one that did not win last time goes.
   function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_gnt);
      if (req == 2'b11) begin
         return last_gnt ? 2'b01 : 2'b10;
      end
      return req;
   endfunction

endpackage

// File: rtl/config_port_arb_if.sv
// Request, response and configurator-port signals of the configurator port arbiter.
interface config_port_arb_if
   import config_port_arb_pkg::*;
#(
   parameter int CAW = CAW_DEF,
   parameter int CDW = CDW_DEF
);

   logic           req0_vld;
   logic           req0_wr;
   logic [CAW-1:0] req0_addr;
   logic [CDW-1:0] req0_wdata;
   logic           req0_rdy;

   logic           req1_vld;
   logic           req1_wr;
   logic [CAW-1:0] req1_addr;
   logic [CDW-1:0] req1_wdata;
   logic           req1_rdy;

   logic           rsp0_vld;
   logic [CDW-1:0] rsp0_rdata;
   logic           rsp0_rdy;

   logic           rsp1_vld;
   logic [CDW-1:0] rsp1_rdata;
   logic           rsp1_rdy;

   logic           config_we;
   logic [CAW-1:0] config_waddr;
   logic [CDW-1:0] config_wdata;
   logic           config_re;
   logic [CAW-1:0] config_raddr;
   logic [CDW-1:0] config_rdata;

   modport slave (
      input  req0_vld, req0_wr, req0_addr, req0_wdata,
      output req0_rdy,
      input  req1_vld, req1_wr, req1_addr, req1_wdata,
      output req1_rdy,
      output rsp0_vld, rsp0_rdata,
      input  rsp0_rdy,
      output rsp1_vld, rsp1_rdata,
      input  rsp1_rdy,
      output config_we, config_waddr, config_wdata, config_re, config_raddr,
      input  config_rdata
   );

   modport master (
      output req0_vld, req0_wr, req0_addr, req0_wdata,
      input  req0_rdy,
      output req1_vld, req1_wr, req1_addr, req1_wdata,
      input  req1_rdy,
      input  rsp0_vld, rsp0_rdata,
      output rsp0_rdy,
      input  rsp1_vld, rsp1_rdata,
      output rsp1_rdy,
      input  config_we, config_waddr, config_wdata, config_re, config_raddr,
      output config_rdata
   );

endinterface

// File: rtl/config_port_arb_rr_arb2.sv
// Two-input round-robin arbiter with enable; one-hot grant, last winner remembered.
module rr_arb2
   import config_port_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic last_gnt;

   assign gnt = en ? rr_pick(req, last_gnt) : 2'b00;

   // Reset to requester 1 so requester 0 wins the first contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt <= 1'b1;
      end else if (|gnt) begin
         last_gnt <= gnt[1];
      end
   end

endmodule

// File: rtl/config_port_arb.sv
// Shares the configurator port between the NoC controller (req 0) and host/debug (req 1).
// Optional response-hold timeout with sticky arb_err: define CFG_ARB_TIMEOUT_EN.
module config_port_arb
   import config_port_arb_pkg::*;
#(
   parameter int CAW    = CAW_DEF,
   parameter int CDW    = CDW_DEF,
   parameter int RD_LAT = 1,
   parameter int TO_CYC = 255
) (
   input  logic             clk_config,
   input  logic             rst_n,
   input  logic             work_config_busy,
   output logic             arb_err,
   config_port_arb_if.slave cfg
);

   localparam logic [1:0] RD_LAT_W = 2'(RD_LAT);

   arb_state_e     state;
   arb_state_e     state_nxt;
   logic [1:0]     req;
   logic [1:0]     gnt;
   logic           arb_en;
   logic           any_gnt;
   logic           sel_wr;
   logic [CAW-1:0] sel_addr;
   logic [CDW-1:0] sel_wdata;
   logic [1:0]     lat_cnt;
   logic           owner;
   logic [1:0]     rsp_vld;
   logic [CDW-1:0] rsp_data;
   logic           capture;
   logic           rsp_drop;
   logic           rsp_hs;
   logic           timeout;

   assign req = {cfg.req1_vld, cfg.req0_vld};

   // Gating with rst_n keeps rdy low while reset is asserted.
   assign arb_en = rst_n & (state == ST_IDLE) & ~work_config_busy;

   rr_arb2 u_rr_arb2 (
      .clk   (clk_config),
      .rst_n (rst_n),
      .en    (arb_en),
      .req   (req),
      .gnt   (gnt)
   );

   assign cfg.req0_rdy = gnt[REQ_NOC];
   assign cfg.req1_rdy = gnt[REQ_DBG];
   assign any_gnt      = |gnt;

   assign sel_wr    = gnt[REQ_DBG] ? cfg.req1_wr    : cfg.req0_wr;
   assign sel_addr  = gnt[REQ_DBG] ? cfg.req1_addr  : cfg.req0_addr;
   assign sel_wdata = gnt[REQ_DBG] ? cfg.req1_wdata : cfg.req0_wdata;

   assign rsp_hs = owner ? cfg.rsp1_rdy : cfg.rsp0_rdy;

   always_ff @(posedge clk_config or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      rsp_drop  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (any_gnt && !sel_wr) begin
               state_nxt = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (lat_cnt == 2'd0) begin
               capture   = 1'b1;
               state_nxt = ST_RSP;
            end
         end
         ST_RSP: begin
            if (rsp_hs || timeout) begin
               rsp_drop  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Stage p0 -> p1: granted request becomes a one-cycle strobe on the configurator port.
   always_ff @(posedge clk_config or negedge rst_n) begin
      if (!rst_n) begin
         cfg.config_we    <= 1'b0;
         cfg.config_re    <= 1'b0;
         cfg.config_waddr <= '0;
         cfg.config_wdata <= '0;
         cfg.config_raddr <= '0;
      end else begin
         cfg.config_we <= any_gnt & sel_wr;
         cfg.config_re <= any_gnt & ~sel_wr;
         if (any_gnt && sel_wr) begin
            cfg.config_waddr <= sel_addr;
            cfg.config_wdata <= sel_wdata;
         end
         if (any_gnt && !sel_wr) begin
            cfg.config_raddr <= sel_addr;
         end
      end
   end

   // Read tracking: wait out the configurator latency, then hold the response for its owner.
   always_ff @(posedge clk_config or negedge rst_n) begin
      if (!rst_n) begin
         lat_cnt  <= 2'd0;
         owner    <= 1'b0;
         rsp_vld  <= 2'b00;
         rsp_data <= '0;
      end else begin
         if (any_gnt && !sel_wr) begin
            owner   <= gnt[REQ_DBG];
            lat_cnt <= RD_LAT_W;
         end else if (state == ST_RD_WAIT && lat_cnt != 2'd0) begin
            lat_cnt <= lat_cnt - 2'd1;
         end
         if (capture) begin
            rsp_data <= cfg.config_rdata;
            rsp_vld  <= owner ? 2'b10 : 2'b01;
         end else if (rsp_drop) begin
            rsp_vld  <= 2'b00;
         end
      end
   end

   assign cfg.rsp0_vld   = rsp_vld[REQ_NOC];
   assign cfg.rsp1_vld   = rsp_vld[REQ_DBG];
   assign cfg.rsp0_rdata = rsp_vld[REQ_NOC] ? rsp_data : '0;
   assign cfg.rsp1_rdata = rsp_vld[REQ_DBG] ? rsp_data : '0;

`ifdef CFG_ARB_TIMEOUT_EN
   localparam logic [7:0] TO_LIM = 8'(TO_CYC - 1);

   logic [7:0] to_cnt;

   assign timeout = (to_cnt == TO_LIM);

   // Counter restarts on every entry to RSP; the response is visible for TO_CYC cycles at most.
   always_ff @(posedge clk_config or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt  <= 8'd0;
         arb_err <= 1'b0;
      end else begin
         to_cnt <= (state == ST_RSP) ? to_cnt + 8'd1 : 8'd0;
         if (state == ST_RSP && timeout && !rsp_hs) begin
            arb_err <= 1'b1;
         end
      end
   end
`else
   assign timeout = 1'b0;
   assign arb_err = 1'b0;
`endif

endmodule
